// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: decoder commands,
// datapath select codes and the control FSM state set.
package mc_control_pkg;

  localparam int CMD_W = 4;
  localparam int ST_W  = 4;

  // Command codes are shared with the instruction decoder; 12-15 are illegal.
  localparam logic [CMD_W-1:0] CMD_LW   = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SW   = 4'd1;
  localparam logic [CMD_W-1:0] CMD_J    = 4'd2;
  localparam logic [CMD_W-1:0] CMD_JAL  = 4'd3;
  localparam logic [CMD_W-1:0] CMD_BEQ  = 4'd4;
  localparam logic [CMD_W-1:0] CMD_BNE  = 4'd5;
  localparam logic [CMD_W-1:0] CMD_XORI = 4'd6;
  localparam logic [CMD_W-1:0] CMD_ADDI = 4'd7;
  localparam logic [CMD_W-1:0] CMD_JR   = 4'd8;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'd9;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'd10;
  localparam logic [CMD_W-1:0] CMD_SLT  = 4'd11;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_SLT = 2'd3;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_SXI     = 2'd2;
  localparam logic [1:0] SRCB_SXI_SH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I, ST_MEM_ADDR,
    ST_MEM_RD, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_JAL, ST_JR
  } state_t;

endpackage

// File: rtl/mc_control.sv
// Multicycle control FSM: steps the shared datapath through each instruction
// and handshakes with a variable-latency memory via mem_req/mem_ack.
module mc_control
  import mc_control_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] cmd,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             instr_done,
  output logic             illegal
);

  state_t           state, state_nxt;
  logic [CMD_W-1:0] cmd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      cmd_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE)
        cmd_q <= cmd;
    end
  end

  // Outputs are forced to zero while reset is high so an in-flight
  // memory request is dropped in the reset cycle itself.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wb_src     = WB_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state_nxt  = state;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_we     = mem_ack;
          pc_we     = mem_ack;
          if (mem_ack)
            state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_SXI_SH2;
          case (cmd)
            CMD_LW, CMD_SW:           state_nxt = ST_MEM_ADDR;
            CMD_ADD, CMD_SUB, CMD_SLT: state_nxt = ST_EXEC_R;
            CMD_ADDI, CMD_XORI:       state_nxt = ST_EXEC_I;
            CMD_BEQ, CMD_BNE:         state_nxt = ST_BRANCH;
            CMD_J:                    state_nxt = ST_JUMP;
            CMD_JAL:                  state_nxt = ST_JAL;
            CMD_JR:                   state_nxt = ST_JR;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_nxt  = ST_FETCH;
            end
          endcase
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          case (cmd_q)
            CMD_SUB: alu_op = ALU_SUB;
            CMD_SLT: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          state_nxt = ST_WB_R;
        end
        ST_WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = DST_RD;
          wb_src     = WB_ALUOUT;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_SXI;
          alu_op    = (cmd_q == CMD_XORI) ? ALU_XOR : ALU_ADD;
          state_nxt = ST_WB_I;
        end
        ST_WB_I: begin
          reg_we     = 1'b1;
          reg_dst    = DST_RT;
          wb_src     = WB_ALUOUT;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_SXI;
          state_nxt = (cmd_q == CMD_LW) ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ack)
            state_nxt = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          reg_we     = 1'b1;
          reg_dst    = DST_RT;
          wb_src     = WB_MDR;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ack) begin
            instr_done = 1'b1;
            state_nxt  = ST_FETCH;
          end
        end
        ST_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_we      = (cmd_q == CMD_BNE) ? !zero : zero;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_JUMP: begin
          pc_we      = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_JAL: begin
          reg_we     = 1'b1;
          reg_dst    = DST_RA;
          wb_src     = WB_PC;
          pc_we      = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        ST_JR: begin
          pc_we      = 1'b1;
          pc_src     = PC_RS;
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a per-instruction model builds the
// expected cycle-by-cycle output vectors from the instruction timing rules.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [3:0] cmd;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a;
  logic       reg_we, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, wb_src;

  int total = 0;
  int bad   = 0;

  logic [18:0] exp_q[$];
  logic        ack_s[$];
  logic        zero_s[$];
  logic [3:0]  cmd_s[$];

  mc_control dut (
    .clk(clk), .reset(reset), .cmd(cmd), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_src(wb_src), .instr_done(instr_done),
    .illegal(illegal)
  );

  wire [18:0] obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_we, reg_dst, wb_src, instr_done,
                     illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(
    input logic req, input logic we, input logic io, input logic irw,
    input logic pcw, input logic [1:0] pcs, input logic sa,
    input logic [1:0] sb, input logic [1:0] op, input logic rw,
    input logic [1:0] dst, input logic [1:0] wb, input logic dn,
    input logic il);
    return {req, we, io, irw, pcw, pcs, sa, sb, op, rw, dst, wb, dn, il};
  endfunction

  // Inputs are applied just after a rising edge; outputs sampled at the falling edge.
  task automatic step(input logic r, input logic a, input logic [3:0] c,
                      input logic z, output logic [18:0] o);
    reset   = r;
    mem_ack = a;
    cmd     = c;
    zero    = z;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic [18:0] e, input logic a);
    exp_q.push_back(e);
    ack_s.push_back(a);
    zero_s.push_back(1'($urandom));
    cmd_s.push_back(4'($urandom));
  endtask

  // Model: fetch (with waits), decode, then the class-specific tail.
  task automatic build(input logic [3:0] c, input int fw, input int mw,
                       input logic bz);
    logic il;
    logic pcw;
    logic [1:0] op;
    exp_q.delete(); ack_s.delete(); zero_s.delete(); cmd_s.delete();
    for (int i = 0; i < fw; i++)
      push_cycle(mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0), 1'b0);
    push_cycle(mk(1'b1,1'b0,1'b0,1'b1,1'b1,2'd0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0), 1'b1);
    il = (c > 4'd11);
    push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd3,2'd0,1'b0,2'd0,2'd0,il,il), 1'($urandom));
    cmd_s[cmd_s.size()-1] = c;
    case (c)
      4'd0, 4'd1: begin
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd2,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0), 1'($urandom));
        for (int i = 0; i < mw; i++)
          push_cycle(mk(1'b1,c[0],1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0), 1'b0);
        push_cycle(mk(1'b1,c[0],1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,c[0],1'b0), 1'b1);
        if (c == 4'd0)
          push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd1,1'b1,1'b0), 1'($urandom));
      end
      4'd2: push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b0), 1'($urandom));
      4'd3: push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,2'd0,2'd0,1'b1,2'd2,2'd2,1'b1,1'b0), 1'($urandom));
      4'd4, 4'd5: begin
        pcw = (c == 4'd4) ? bz : !bz;
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,pcw,2'd1,1'b1,2'd0,2'd1,1'b0,2'd0,2'd0,1'b1,1'b0), 1'($urandom));
        zero_s[zero_s.size()-1] = bz;
      end
      4'd6, 4'd7: begin
        op = (c == 4'd6) ? 2'd2 : 2'd0;
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd2,op,1'b0,2'd0,2'd0,1'b0,1'b0), 1'($urandom));
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd0,1'b1,1'b0), 1'($urandom));
      end
      4'd8: push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd3,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b0), 1'($urandom));
      4'd9, 4'd10, 4'd11: begin
        op = (c == 4'd9) ? 2'd0 : (c == 4'd10) ? 2'd1 : 2'd3;
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd0,op,1'b0,2'd0,2'd0,1'b0,1'b0), 1'($urandom));
        push_cycle(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd1,2'd0,1'b1,1'b0), 1'($urandom));
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    logic [18:0] o;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'($urandom), 1'($urandom), o);
      total++;
      if (o !== 19'd0) begin
        bad++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%h want=%h", i, o, 19'd0);
      end
    end
    step(1'b0, 1'b0, 4'($urandom), 1'($urandom), o);
    total++;
    if (o !== mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0)) begin
      bad++;
      $display("[TB] FAIL first_fetch got=%h want req=1 iord=0 srcb=1", o);
    end
  endtask

  task automatic test_add();
    logic [18:0] o;
    build(4'd9, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL add cyc=%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_lw_waits();
    logic [18:0] o;
    build(4'd0, 2, 2, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL lw_wait cyc=%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [18:0] o;
    for (int k = 0; k < 4; k++) begin
      build((k < 2) ? 4'd4 : 4'd5, 0, 0, k[0]);
      for (int i = 0; i < exp_q.size(); i++) begin
        step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
        total++;
        if (o !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL branch k=%0d cyc=%0d got=%h want=%h", k, i, o, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_jal_illegal();
    logic [18:0] o;
    for (int k = 0; k < 3; k++) begin
      build((k == 0) ? 4'd3 : (k == 1) ? 4'd13 : 4'd9, 0, 0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
        total++;
        if (o !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL jal_illegal k=%0d cyc=%0d got=%h want=%h", k, i, o, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [18:0] o;
    logic [3:0]  c;
    for (int n = 0; n < 60; n++) begin
      c = 4'($urandom);
      build(c, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
        total++;
        if (o !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL random n=%0d cmd=%0d cyc=%0d got=%h want=%h", n, c, i, o, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [18:0] o;
    build(4'd1, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL sw_pre_reset cyc=%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    step(1'b1, 1'b0, 4'($urandom), 1'($urandom), o);
    total++;
    if (o !== 19'd0) begin
      bad++;
      $display("[TB] FAIL reset_in_mem_wr got=%h want=%h", o, 19'd0);
    end
    step(1'b0, 1'b0, 4'($urandom), 1'($urandom), o);
    total++;
    if (o !== mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0)) begin
      bad++;
      $display("[TB] FAIL fetch_after_reset got=%h want fetch-wait vector", o);
    end
    build(4'd10, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(1'b0, ack_s[i], cmd_s[i], zero_s[i], o);
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL sub_after_reset cyc=%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    mem_ack = 1'b1;
    cmd     = 4'd0;
    zero    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_lw_waits();
    test_branch();
    test_jal_illegal();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control FSM for the MIPS core. Sequences the shared datapath (PC, IR, register file, ALU, ALUOut, MDR, single shared memory port) through fetch/decode/execute/memory/writeback for each instruction.
- Consumes the 4-bit command from the instruction decoder plus the ALU zero flag.
- Drives all datapath enables and selects, and runs a req/ack handshake with a variable-latency memory.

Parameters:
- CMD_W, 4, width of decoder command.
- ST_W, 4, width of state register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd  in  CMD_W  decoded command from decoder (valid from DECODE state onward).
- zero  in  1  ALU zero flag (combinational, current cycle).
- mem_ack  in  1  memory completes access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  request is a write.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_we  out  1  load IR and MDR.
- pc_we  out  1  load PC.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],jAddr}, 3=rs value.
- alu_src_a  out  1  0=PC, 1=A register.
- alu_src_b  out  2  0=B, 1=constant 4, 2=sxi, 3=sxi<<2.
- alu_op  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT.
- reg_we  out  1  register file write.
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- wb_src  out  2  0=ALUOut, 1=MDR, 2=PC.
- instr_done  out  1  one-cycle pulse on final cycle of each instruction.
- illegal  out  1  one-cycle pulse when an unknown cmd is dispatched.

Behaviour:
- Command encoding (shared): LW=0, SW=1, J=2, JAL=3, BEQ=4, BNE=5, XORI=6, ADDI=7, JR=8, ADD=9, SUB=10, SLT=11; 12-15 illegal.
- Registered: state, and cmd_q (cmd captured in DECODE). All outputs are combinational from state, cmd_q, zero and mem_ack. Unlisted outputs are 0 in every state.
- While reset=1, all outputs are 0. Next edge: state=FETCH.
- Reset mid-transaction: mem_req drops in the reset cycle. The memory must tolerate an abandoned request.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_we=mem_ack, pc_we=mem_ack.
  - Hold until mem_ack=1, then go to DECODE. Ack may arrive in the request cycle (0 wait).
- DECODE:
  - ALUOut <= PC + (sxi<<2): alu_src_a=0, alu_src_b=3, ADD.
  - cmd_q <= cmd.
  - Dispatch: LW/SW -> MEM_ADDR; ADD/SUB/SLT -> EXEC_R; ADDI/XORI -> EXEC_I; BEQ/BNE -> BRANCH; J -> JUMP; JAL -> JAL; JR -> JR; illegal -> FETCH with illegal=1 and instr_done=1.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from cmd_q (ADD/SUB/SLT) -> WB_R.
- WB_R: reg_we=1, reg_dst=1, wb_src=0, instr_done=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op ADD (ADDI) or XOR (XORI) -> WB_I.
- WB_I: reg_we=1, reg_dst=0, wb_src=0, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD:
  - mem_req=1, iord=1, ir_we is 0; MDR loads when mem_ack=1 (datapath MDR always latches on ack in this state).
  - Hold until ack, then -> MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, wb_src=1, instr_done=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until ack; on ack, instr_done=1 -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_we = zero (BEQ) or !zero (BNE).
  - instr_done=1 -> FETCH.
- JUMP: pc_we=1, pc_src=2, instr_done=1 -> FETCH.
- JAL: reg_we=1, reg_dst=2, wb_src=2 (PC already +4), pc_we=1, pc_src=2, instr_done=1 -> FETCH.
- JR: pc_we=1, pc_src=3, instr_done=1 -> FETCH.
- Cycle counts with zero-wait memory:
  - R-type, ADDI, XORI, SW: 4.
  - LW: 5.
  - BEQ, BNE, J, JAL, JR: 3.
  - Each memory wait cycle adds 1.
- Unreachable state encodings recover to FETCH on the next edge with all outputs 0.

Decomposition:
- Shared package/header:
  - Command encodings (also used by the decoder).
  - ALU op, alu_src_b, pc_src, reg_dst and wb_src select encodings.
  - State encodings.
- No sub-module. Single next-state/output block plus state and cmd_q registers.

Test Plan:
- Reset held 3 cycles with mem_ack=1 -> all outputs 0. First cycle after release: mem_req=1, iord=0.
- cmd=ADD (9), zero-wait memory -> states FETCH, DECODE, EXEC_R, WB_R. reg_we=1 with reg_dst=1 only in cycle 4; instr_done pulses in cycle 4.
- cmd=LW with mem_ack delayed 2 cycles in both FETCH and MEM_RD -> 9 cycles total. mem_req stays continuous in each wait; iord=1 in MEM_RD; reg_we with wb_src=1 in the final cycle.
- cmd=BEQ with zero=0 -> pc_we=0 in BRANCH. With zero=1 -> pc_we=1, pc_src=1. cmd=BNE gives the inverse result.
- cmd=JAL -> third cycle shows reg_we=1, reg_dst=2, wb_src=2, pc_we=1, pc_src=2. cmd=13 -> illegal and instr_done pulse in DECODE, then next state is FETCH.
- Reset asserted in MEM_WR while waiting on ack -> mem_req=0 that cycle; state is FETCH after release; no reg_we or pc_we glitch.
